// File: rtl/phy_rx_pkg.sv
// Shared definitions for the serial lane receiver: comma symbol, lock depth and FSM encoding.
package phy_rx_pkg;

  localparam int unsigned WORD_W          = 8;
  localparam int unsigned BIT_CNT_W       = 3;
  localparam int unsigned COMMA_CNT_W     = 4;
  localparam int unsigned STATE_W         = 2;

  localparam logic [WORD_W-1:0] COMMA_SYM       = 8'hBC;
  localparam int unsigned       COMMA_COUNT_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_ACTIVE  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_serial_lane.sv
// One receive lane: MSB-first deserializer that hunts for the comma symbol,
// locks after COMMA_COUNT aligned commas, then emits one word per 8 bit clocks.
module phy_rx_serial_lane
  import phy_rx_pkg::*;
#(
  parameter logic [WORD_W-1:0] COMMA       = COMMA_SYM,
  parameter int unsigned       COMMA_COUNT = COMMA_COUNT_DEF
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_stb,
  output logic              active
);

  localparam logic [COMMA_CNT_W-1:0] COMMA_TARGET = COMMA_CNT_W'(COMMA_COUNT);
  localparam logic [BIT_CNT_W-1:0]   LAST_BIT     = BIT_CNT_W'(WORD_W - 1);

  // Only the seven most recent bits are kept; the eighth is the live input.
  logic [WORD_W-2:0]      sr, sr_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [COMMA_CNT_W-1:0] comma_cnt, comma_cnt_nxt;
  rx_state_e              state, state_nxt;
  logic [WORD_W-1:0]      data_nxt;
  logic                   valid_nxt;
  logic                   stb_nxt;
  logic                   active_nxt;

  logic [WORD_W-1:0]      w;
  logic                   is_comma;
  logic                   boundary;

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      state     <= ST_SEARCH;
      data_out  <= '0;
      valid_out <= 1'b0;
      byte_stb  <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr        <= sr_nxt;
      bit_cnt   <= bit_cnt_nxt;
      comma_cnt <= comma_cnt_nxt;
      state     <= state_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      byte_stb  <= stb_nxt;
      active    <= active_nxt;
    end
  end

  always_comb begin
    w             = {sr, data_in};
    is_comma      = (w == COMMA);
    boundary      = (bit_cnt == LAST_BIT);

    sr_nxt        = w[WORD_W-2:0];
    bit_cnt_nxt   = bit_cnt + BIT_CNT_W'(1);
    comma_cnt_nxt = comma_cnt;
    state_nxt     = state;
    data_nxt      = data_out;
    valid_nxt     = valid_out;
    stb_nxt       = 1'b0;
    active_nxt    = active;

    case (state)
      ST_SEARCH: begin
        // Bit-granular hunt; alignment is taken from the edge that completes a comma.
        bit_cnt_nxt = '0;
        if (is_comma) begin
          comma_cnt_nxt = COMMA_CNT_W'(1);
          if (COMMA_COUNT == 1) begin
            state_nxt  = ST_ACTIVE;
            active_nxt = 1'b1;
          end else begin
            state_nxt  = ST_LOCKING;
          end
        end
      end

      ST_LOCKING: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_nxt = comma_cnt + COMMA_CNT_W'(1);
            if (comma_cnt_nxt == COMMA_TARGET) begin
              state_nxt  = ST_ACTIVE;
              active_nxt = 1'b1;
            end
          end else begin
            comma_cnt_nxt = '0;
            bit_cnt_nxt   = '0;
            state_nxt     = ST_SEARCH;
          end
        end
      end

      ST_ACTIVE: begin
        if (boundary) begin
          stb_nxt = 1'b1;
          if (is_comma) begin
            valid_nxt = 1'b0;
          end else begin
            data_nxt  = w;
            valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt     = ST_SEARCH;
        bit_cnt_nxt   = '0;
        comma_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_phy_rx_serial_lane.sv
// Directed self-checking bench for phy_rx_serial_lane (default lock depth and a single-comma build).
module tb_phy_rx_serial_lane;

  logic       clk_8f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out, data_out1;
  logic       valid_out, valid_out1;
  logic       byte_stb, byte_stb1;
  logic       active, active1;

  int total;
  int bad;

  logic [7:0] cm;

  phy_rx_serial_lane dut (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .byte_stb (byte_stb),
    .active   (active)
  );

  phy_rx_serial_lane #(.COMMA(8'hBC), .COMMA_COUNT(1)) dut1 (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out1),
    .valid_out(valid_out1),
    .byte_stb (byte_stb1),
    .active   (active1)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  // Drive one bit, let the edge sample it, then settle before checks.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b1;
    @(posedge clk_8f);
    #1;
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data got=%0h want=00", data_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", valid_out); end
    total++; if (byte_stb !== 1'b0) begin bad++; $display("FAIL rst_stb got=%0b want=0", byte_stb); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_active got=%0b want=0", active); end
  endtask

  task automatic test_commas();
    int n;
    n = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(cm[i]);
        n++;
        total++; if (active !== (n == 32)) begin bad++; $display("FAIL commas_active bit=%0d got=%0b want=%0b", n, active, (n == 32)); end
        total++; if (byte_stb !== 1'b0) begin bad++; $display("FAIL commas_stb bit=%0d got=%0b want=0", n, byte_stb); end
      end
    end
    for (int i = 7; i >= 0; i--) begin
      send_bit(cm[i]);
      total++; if (byte_stb !== (i == 0)) begin bad++; $display("FAIL commas_first_stb i=%0d got=%0b want=%0b", i, byte_stb, (i == 0)); end
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL commas_valid i=%0d got=%0b want=0", i, valid_out); end
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL commas_data i=%0d got=%0h want=00", i, data_out); end
    end
  endtask

  task automatic test_offset();
    logic [7:0] d;
    int n;
    d = 8'hA5;
    n = 0;
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    n = 3;
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(cm[i]);
        n++;
        total++; if (active !== (n == 35)) begin bad++; $display("FAIL offset_active bit=%0d got=%0b want=%0b", n, active, (n == 35)); end
      end
    end
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i]);
      total++; if (byte_stb !== (i == 0)) begin bad++; $display("FAIL offset_stb i=%0d got=%0b want=%0b", i, byte_stb, (i == 0)); end
    end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL offset_data got=%0h want=a5", data_out); end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL offset_valid got=%0b want=1", valid_out); end
    send_bit(cm[7]);
    total++; if (byte_stb !== 1'b0) begin bad++; $display("FAIL offset_stb_one_cycle got=%0b want=0", byte_stb); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL offset_data_hold got=%0h want=a5", data_out); end
  endtask

  task automatic test_bad_lock();
    logic [7:0] seq [8];
    int n;
    seq = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    n = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(seq[k][i]);
        n++;
        total++; if (active !== (n == 64)) begin bad++; $display("FAIL badlock_active bit=%0d got=%0b want=%0b", n, active, (n == 64)); end
      end
    end
  endtask

  // Continues from the locked state left by test_bad_lock.
  task automatic test_stream();
    logic [7:0] seq [3];
    logic [7:0] exp_d [3];
    logic       exp_v [3];
    seq   = '{8'h12, 8'hBC, 8'h34};
    exp_d = '{8'h12, 8'h12, 8'h34};
    exp_v = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(seq[k][i]);
        total++; if (byte_stb !== (i == 0)) begin bad++; $display("FAIL stream_stb word=%0d i=%0d got=%0b want=%0b", k, i, byte_stb, (i == 0)); end
      end
      total++; if (data_out !== exp_d[k]) begin bad++; $display("FAIL stream_data word=%0d got=%0h want=%0h", k, data_out, exp_d[k]); end
      total++; if (valid_out !== exp_v[k]) begin bad++; $display("FAIL stream_valid word=%0d got=%0b want=%0b", k, valid_out, exp_v[k]); end
      total++; if (active !== 1'b1) begin bad++; $display("FAIL stream_active word=%0d got=%0b want=1", k, active); end
    end
  endtask

  // Continues from the locked state left by test_stream.
  task automatic test_reset_mid();
    int n;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    reset = 1'b1;
    send_bit(1'b1);
    reset = 1'b0;
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data got=%0h want=00", data_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", valid_out); end
    total++; if (byte_stb !== 1'b0) begin bad++; $display("FAIL midrst_stb got=%0b want=0", byte_stb); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL midrst_active got=%0b want=0", active); end
    n = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(cm[i]);
        n++;
        total++; if (active !== (n == 32)) begin bad++; $display("FAIL midrst_relock bit=%0d got=%0b want=%0b", n, active, (n == 32)); end
      end
    end
  endtask

  task automatic test_count1();
    logic [7:0] d;
    d = 8'hFF;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      send_bit(cm[i]);
      total++; if (active1 !== (i == 0)) begin bad++; $display("FAIL cnt1_active i=%0d got=%0b want=%0b", i, active1, (i == 0)); end
    end
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i]);
      total++; if (byte_stb1 !== (i == 0)) begin bad++; $display("FAIL cnt1_stb i=%0d got=%0b want=%0b", i, byte_stb1, (i == 0)); end
    end
    total++; if (data_out1 !== 8'hFF) begin bad++; $display("FAIL cnt1_data got=%0h want=ff", data_out1); end
    total++; if (valid_out1 !== 1'b1) begin bad++; $display("FAIL cnt1_valid got=%0b want=1", valid_out1); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cm      = 8'hBC;
    reset   = 1'b1;
    data_in = 1'b0;
    test_reset();
    test_commas();
    test_offset();
    test_bad_lock();
    test_stream();
    test_reset_mid();
    test_count1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
